// File: rtl/vram_slot_arbiter.sv
// Time-division arbiter for the shared video SRAM: video owns the video_slice-high window,
// CPU and aux share the low window. One access per window, then a one-cycle ack.
module vram_slot_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned AUX_STARVE = 4
) (
  input  logic              clk24,
  input  logic              reset_n,
  input  logic              video_slice,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_drive
);

  localparam int unsigned    StW         = $clog2(AUX_STARVE + 1);
  localparam logic [1:0]     AccLast     = 2'(ACC_CYCLES);
  localparam logic [StW-1:0] StreakMax   = StW'(AUX_STARVE);
  localparam logic           SingleCycle = (ACC_CYCLES == 32'd1);

  typedef enum logic [1:0] {StIdle, StVid, StCpu, StAux} state_e;

  state_e            state_q, state_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [StW-1:0]    streak_q, streak_d;
  logic              vs_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              vid_ack_q, vid_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              aux_ack_q, aux_ack_d;

  logic win_v, win_s, aux_forced;

  assign win_v      = video_slice & ~vs_q;
  assign win_s      = ~video_slice & vs_q;
  assign aux_forced = aux_req & (streak_q == StreakMax);

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      acc_cnt_q   <= '0;
      streak_q    <= '0;
      vs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      streak_q    <= streak_d;
      vs_q        <= video_slice;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      aux_ack_q   <= aux_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    streak_d    = streak_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    aux_ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_v) begin
          if (vid_req) begin
            state_d   = StVid;
            acc_cnt_d = 2'd1;
            we_d      = 1'b0;
            addr_d    = vid_addr;
          end
        end else if (win_s) begin
          // Aux wins when forced by the streak or when the CPU is not asking.
          if (aux_forced || (aux_req && !cpu_req)) begin
            state_d   = StAux;
            acc_cnt_d = 2'd1;
            we_d      = aux_we;
            addr_d    = aux_addr;
            streak_d  = '0;
            if (aux_we) begin
              dout_d = aux_wdata;
            end
          end else if (cpu_req) begin
            state_d   = StCpu;
            acc_cnt_d = 2'd1;
            we_d      = cpu_we;
            addr_d    = cpu_addr;
            streak_d  = aux_req ? streak_q + StW'(1) : '0;
            if (cpu_we) begin
              dout_d = cpu_wdata;
            end
          end else begin
            streak_d = '0;
          end
        end
      end
      default: begin
        if (acc_cnt_q == AccLast) begin
          state_d   = StIdle;
          acc_cnt_d = '0;
          if (state_q == StVid) begin
            vid_ack_d  = 1'b1;
            vid_data_d = sram_din;
          end else if (state_q == StCpu) begin
            cpu_ack_d = 1'b1;
            if (!we_q) begin
              cpu_rdata_d = sram_din;
            end
          end else begin
            aux_ack_d = 1'b1;
            if (!we_q) begin
              aux_rdata_d = sram_din;
            end
          end
        end else begin
          acc_cnt_d = acc_cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_drive = 1'b0;
    if (state_q != StIdle) begin
      if (we_q) begin
        sram_drive = 1'b1;
        // First cycle lets address and data settle before the write strobe.
        sram_we_n  = ~(SingleCycle || (acc_cnt_q >= 2'd2));
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign vid_data  = vid_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign aux_ack   = aux_ack_q;

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
Time-division arbiter for the single shared SRAM in the 24 MHz domain. It is slotted by the video_slice window from the clock generator.
- Video-high window: reserved for the video fetcher.
- Video-low window: shared between the CPU and an auxiliary requester (ROM loader / disk DMA).
- Drives the SRAM control pins and returns read data with one-cycle acknowledges.

Parameters:
ADDR_W, 18, SRAM address width for all requesters
DATA_W, 8, SRAM data width
ACC_CYCLES, 2, length of one SRAM access in clk24 cycles; legal range 1..3
AUX_STARVE, 4, consecutive CPU grants while aux pending before aux is forced one slot

Ports:
clk24  in  1  24 MHz system clock
reset_n  in  1  asynchronous active-low reset
video_slice  in  1  slot phase from clock generator; high 4 cycles, low 4 cycles
vid_req  in  1  video read request
vid_addr  in  ADDR_W  video address
vid_ack  out  1  one-cycle pulse, vid_data valid
vid_data  out  DATA_W  video read data, held until next video ack
cpu_req  in  1  CPU request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle pulse on completion
cpu_rdata  out  DATA_W  CPU read data, held until next CPU read ack
aux_req, aux_we, aux_addr, aux_wdata, aux_ack, aux_rdata  as cpu_* for auxiliary requester
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  DATA_W  SRAM write data
sram_din  in  DATA_W  SRAM read data
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_drive  out  1  1 = tristate buffer drives sram_dout onto bus

Behaviour:
- Window starts are detected from registered video_slice (vs_d).
  - Video start (V): video_slice & ~vs_d.
  - Shared start (S): ~video_slice & vs_d.
- Requests are sampled only on the window-start cycle. A request raised later in a window waits for the next window of its type.
- At most one access per window; the SRAM idles for the rest of the window.
- States: IDLE, VID, CPU, AUX; ACC_CYCLES-deep access counter acc_cnt.
- At V:
  - vid_req=1 -> VID.
  - Otherwise stay IDLE; the CPU/aux never use a video window.
- At S:
  - Forced aux: aux_req & streak==AUX_STARVE -> AUX.
  - Else cpu_req -> CPU.
  - Else aux_req -> AUX.
  - Else IDLE.
- Streak counter:
  - Increments on each CPU grant while aux_req=1, saturating at AUX_STARVE.
  - Clears on an AUX grant or on any S with aux_req=0.
- Access cycles k=1..ACC_CYCLES:
  - sram_addr is registered from the granted address at grant and held through the access.
  - Read: sram_oe_n=0 for all k; sram_din captured into the requester's rdata register at k=ACC_CYCLES.
  - Write: sram_drive=1 for all k; sram_we_n=0 for k>=2, or k=1 when ACC_CYCLES=1; sram_oe_n=1.
  - VID is always a read; vid_req carries no write.
- ack pulses for exactly one cycle, on the cycle after k=ACC_CYCLES. The state returns to IDLE on that same cycle.
- Requesters drop req on the cycle after ack. A req still high at the next window start is a new request.
- Latency, window start to ack: ACC_CYCLES+1 cycles. This always lies within the 4-cycle window for ACC_CYCLES<=3.
- Idle outputs: sram_oe_n=1, sram_we_n=1, sram_drive=0; sram_addr holds its last value.
- Simultaneous V and S cannot occur. A V/S edge arriving mid-access is impossible with legal ACC_CYCLES and is ignored.
- Reset, including mid-access, is immediate and asynchronous:
  - State IDLE, acc_cnt=0, streak=0, vs_d=0.
  - sram_oe_n=1, sram_we_n=1, sram_drive=0, sram_addr=0, sram_dout=0.
  - All acks 0, all rdata/vid_data 0.
  - An aborted access produces no ack.

Test Plan:
- Reset: hold reset_n=0 mid-write (sram_we_n=0) -> sram_we_n=1, sram_drive=0, no cpu_ack, all data outputs 0 within the same cycle.
- Video read, ACC_CYCLES=2, vid_addr=0x1A5A0, sram_din=0x3C -> sram_oe_n low 2 cycles from V+1; vid_ack pulses at V+3; vid_data=0x3C.
- CPU write 0x5A to 0x00100 -> sram_we_n low exactly 1 cycle, in the 2nd access cycle; sram_drive high 2 cycles; cpu_ack at S+3; no activity in the video window.
- cpu_req and aux_req held continuously, AUX_STARVE=4 -> grants CPU,CPU,CPU,CPU,AUX repeating; aux_ack once every 5 shared windows.
- cpu_req raised 1 cycle after S -> no access that window; served at the next S, cpu_ack 3 cycles after it.
- ACC_CYCLES=1 and 3 sweep with back-to-back vid/cpu requests -> one access per window, ack at window start + ACC_CYCLES+1, sram_oe_n never low in an empty window.
